// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants: the 640x480 @ 60 Hz defaults, the derived
// totals and the coordinate counter width. Renderers import this too.
package vga_timing_pkg;

  localparam int CNT_W   = 10;
  localparam int CNT_MAX = 1 << CNT_W;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

endpackage

// File: rtl/clk_en_div.sv
// Pixel-tick generator: a free-running 0..CLK_DIV-1 counter whose last
// count produces a one-cycle enable. With CLK_DIV = 1 the enable is always
// high because the counter never leaves zero.
import vga_timing_pkg::*;

module clk_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic en
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  // divider counter, wraps at CLK_DIV-1
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign en = (div_cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Horizontal/vertical position counters step
// on each pixel tick; bright and the active-low syncs are registered from
// the next-state counters so every raster output describes the same (h,v).
import vga_timing_pkg::*;

module vga_timing_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = vga_timing_pkg::H_VIS,
  parameter int H_FP    = vga_timing_pkg::H_FP,
  parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
  parameter int H_BP    = vga_timing_pkg::H_BP,
  parameter int V_VIS   = vga_timing_pkg::V_VIS,
  parameter int V_FP    = vga_timing_pkg::V_FP,
  parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
  parameter int V_BP    = vga_timing_pkg::V_BP
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pix_en,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             bright,
  output logic             hSync,
  output logic             vSync,
  output logic             frame_start,
  output logic [15:0]      frame_cnt
);

  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG = H_VIS + H_FP;
  localparam int HS_END = H_VIS + H_FP + H_SYNC;
  localparam int VS_BEG = V_VIS + V_FP;
  localparam int VS_END = V_VIS + V_FP + V_SYNC;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);

  // Totals must fit the 10-bit coordinate counters.
  if (H_TOT > CNT_MAX || V_TOT > CNT_MAX) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic             h_last;
  logic             v_last;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             bright_next;
  logic             hsync_next;
  logic             vsync_next;

  clk_en_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en)
  );

  assign h_last      = (hCount == H_LAST);
  assign v_last      = (vCount == V_LAST);
  assign frame_start = pix_en && h_last && v_last;

  // next-state raster position and the decodes that go with it
  always_comb begin
    h_next = hCount;
    v_next = vCount;
    if (pix_en) begin
      h_next = h_last ? '0 : hCount + CNT_W'(1);
      if (h_last) begin
        v_next = v_last ? '0 : vCount + CNT_W'(1);
      end
    end
    bright_next = (int'(h_next) < H_VIS) && (int'(v_next) < V_VIS);
    hsync_next  = !((int'(h_next) >= HS_BEG) && (int'(h_next) < HS_END));
    vsync_next  = !((int'(v_next) >= VS_BEG) && (int'(v_next) < VS_END));
  end

  // position, decoded raster outputs and completed-frame count
  always_ff @(posedge clk) begin
    if (reset) begin
      hCount    <= '0;
      vCount    <= '0;
      bright    <= 1'b1;
      hSync     <= 1'b1;
      vSync     <= 1'b1;
      frame_cnt <= '0;
    end else begin
      hCount <= h_next;
      vCount <= v_next;
      bright <= bright_next;
      hSync  <= hsync_next;
      vSync  <= vsync_next;
      if (frame_start) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (reduced raster with CLK_DIV=3,
// the same raster with CLK_DIV=1, and the default 640x480 CLK_DIV=4) checked
// every cycle against an arithmetic model of the raster position.
module tb_vga_timing_gen;

  localparam int S_HV = 20, S_HF = 3, S_HS = 5, S_HB = 4;
  localparam int S_VV = 10, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;   // 32
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;   // 17

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       a_pix, a_br, a_hs, a_vs, a_fs;
  logic [9:0] a_h, a_v;
  logic [15:0] a_fc;
  logic       b_pix, b_br, b_hs, b_vs, b_fs;
  logic [9:0] b_h, b_v;
  logic [15:0] b_fc;
  logic       c_pix, c_br, c_hs, c_vs, c_fs;
  logic [9:0] c_h, c_v;
  logic [15:0] c_fc;

  vga_timing_gen #(
    .CLK_DIV(3), .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) dut_a (
    .clk(clk), .reset(reset), .pix_en(a_pix), .hCount(a_h), .vCount(a_v),
    .bright(a_br), .hSync(a_hs), .vSync(a_vs), .frame_start(a_fs), .frame_cnt(a_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) dut_b (
    .clk(clk), .reset(reset), .pix_en(b_pix), .hCount(b_h), .vCount(b_v),
    .bright(b_br), .hSync(b_hs), .vSync(b_vs), .frame_start(b_fs), .frame_cnt(b_fc)
  );

  vga_timing_gen dut_c (
    .clk(clk), .reset(reset), .pix_en(c_pix), .hCount(c_h), .vCount(c_v),
    .bright(c_br), .hSync(c_hs), .vSync(c_vs), .frame_start(c_fs), .frame_cnt(c_fc)
  );

  typedef struct {
    int pix; int h; int v; int br; int hs; int vs; int fs; int fc;
  } exp_t;

  // k = clocks since the last reset edge; ticks completed = k / d.
  function automatic exp_t model(longint k, int d, int hv, int hf, int hs, int hb,
                                 int vv, int vf, int vs, int vb);
    exp_t   e;
    int     ht, vt;
    longint ticks, pos;
    ht    = hv + hf + hs + hb;
    vt    = vv + vf + vs + vb;
    ticks = k / d;
    pos   = ticks % (ht * vt);
    e.h   = int'(pos % ht);
    e.v   = int'(pos / ht);
    e.pix = ((k % d) == d - 1) ? 1 : 0;
    e.fc  = int'((ticks / (ht * vt)) % 65536);
    e.br  = (e.h < hv && e.v < vv) ? 1 : 0;
    e.hs  = (e.h >= hv + hf && e.h < hv + hf + hs) ? 0 : 1;
    e.vs  = (e.v >= vv + vf && e.v < vv + vf + vs) ? 0 : 1;
    e.fs  = (e.pix == 1 && e.h == ht - 1 && e.v == vt - 1) ? 1 : 0;
    return e;
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(string tag, longint obs, longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic chk_inst(string nm, exp_t e, logic pix, logic [9:0] h, logic [9:0] v,
                          logic br, logic hs, logic vs, logic fs, logic [15:0] fc);
    chk({nm, ".pix_en"}, pix, e.pix);
    chk({nm, ".hCount"}, h, e.h);
    chk({nm, ".vCount"}, v, e.v);
    chk({nm, ".bright"}, br, e.br);
    chk({nm, ".hSync"}, hs, e.hs);
    chk({nm, ".vSync"}, vs, e.vs);
    chk({nm, ".frame_start"}, fs, e.fs);
    chk({nm, ".frame_cnt"}, fc, e.fc);
  endtask

  longint k = 0;
  bit     agg_on = 0;
  int     a_bt = 0, a_vl = 0, a_frames = 0;
  longint a_last = 0;
  int     c_bt = 0, c_hl = 0, c_first = -1;
  bit     c_done = 0, b_done = 0;

  task automatic step();
    exp_t ea, eb, ec;
    @(posedge clk);
    if (reset) k = 0;
    else k++;
    @(negedge clk);
    ea = model(k, 3, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
    eb = model(k, 1, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
    ec = model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    chk_inst("a", ea, a_pix, a_h, a_v, a_br, a_hs, a_vs, a_fs, a_fc);
    chk_inst("b", eb, b_pix, b_h, b_v, b_br, b_hs, b_vs, b_fs, b_fc);
    chk_inst("c", ec, c_pix, c_h, c_v, c_br, c_hs, c_vs, c_fs, c_fc);
    if (agg_on) begin
      if (a_pix && a_br) a_bt++;
      if (a_pix && !a_vs) a_vl++;
      if (a_fs) begin
        a_frames++;
        chk("a.frame_period", k + 1 - a_last, S_HT * S_VT * 3);
        chk("a.bright_ticks", a_bt, S_HV * S_VV);
        chk("a.vsync_ticks", a_vl, S_VS * S_HT);
        chk("a.frame_cnt_at_pulse", a_fc, a_frames - 1);
        a_last = k + 1;
        a_bt = 0;
        a_vl = 0;
      end
      if (!c_done) begin
        if (c_pix && !c_hs) begin
          if (c_hl == 0) c_first = int'(c_h);
          c_hl++;
        end
        if (c_pix && c_br) c_bt++;
        if (c_pix && c_h == 10'd799) begin
          chk("c.hsync_ticks", c_hl, 96);
          chk("c.hsync_start", c_first, 656);
          chk("c.bright_ticks", c_bt, 640);
          chk("c.line_clocks", k + 1, 3200);
          c_done = 1;
        end
      end
      if (!b_done && b_pix && int'(b_h) == S_HT - 1) begin
        chk("b.line_clocks", k + 1, S_HT);
        b_done = 1;
      end
    end
  endtask

  initial begin
    bit found;
    int rst_left;

    // reset held for 5 cycles, then three reduced frames uninterrupted
    reset = 1'b1;
    repeat (5) step();
    reset = 1'b0;
    agg_on = 1;
    repeat (3 * S_HT * S_VT * 3 + 20) step();
    agg_on = 0;
    chk("a.frames_seen", a_frames, 3);
    chk("a.frame_cnt_after3", a_fc, 3);
    chk("c.line_seen", c_done, 1);
    chk("b.line_seen", b_done, 1);

    // single-cycle reset mid-frame at (25,8) on the reduced raster
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (a_h == 10'd25 && a_v == 10'd8) found = 1;
      else step();
    end
    chk("a.midrst_reached", found, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("a.midrst_h", a_h, 0);
    chk("a.midrst_v", a_v, 0);
    chk("a.midrst_fc", a_fc, 0);
    chk("a.midrst_hsync", a_hs, 1);

    // random reset pulses over a long run
    rst_left = 0;
    for (int i = 0; i < 5000; i++) begin
      if (rst_left > 0) begin
        reset = 1'b1;
        rst_left--;
      end else begin
        reset = 1'b0;
        if ($urandom_range(0, 1999) == 0) rst_left = int'($urandom_range(1, 4));
      end
      step();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
